// File: rtl/mul_8x8_pkg.sv
// ============================================================================
// mul_8x8_pkg : shared widths and state encoding for the shift-and-add multiplier
// Revision 1.0
// ============================================================================
`default_nettype none

package mul_8x8_pkg;

    localparam int WIDTH  = 8;
    localparam int PROD_W = 2 * WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : mul_8x8_pkg

`default_nettype wire

// File: rtl/sum_16.sv
// ============================================================================
// sum_16 : combinational 16-bit adder, carry out discarded
// Revision 1.0
// ============================================================================
`default_nettype none

module sum_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result
);

    assign result = a + b;

endmodule : sum_16

`default_nettype wire

// File: rtl/mul_8x8.sv
// ============================================================================
// mul_8x8 : unsigned sequential shift-and-add multiplier, fixed WIDTH-cycle
//           latency, accumulation done by an external adder
// Revision 1.0
// ============================================================================
`default_nettype none

module mul_8x8
    import mul_8x8_pkg::*;
#(
    parameter int WIDTH = mul_8x8_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   sum_in_a,
    output logic [2*WIDTH-1:0]   sum_in_b,
    input  logic [2*WIDTH-1:0]   sum_out
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      result_q, result_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        sum_in_a = '0;
        sum_in_b = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_i};
                    mplier_d = b_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // One partial product per cycle; zero operands still take all steps.
                sum_in_a = acc_q;
                sum_in_b = mplier_q[0] ? mcand_q : '0;
                acc_d    = sum_out;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    result_d = sum_out;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy   = (state_q == ST_RUN);
    assign result = result_q;

endmodule : mul_8x8

`default_nettype wire

// File: tb/tb_mul_8x8.sv
// ============================================================================
// tb_mul_8x8 : directed stimulus with a queue-based scoreboard for mul_8x8
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mul_8x8;

    logic        clk;
    logic        rst;
    logic [7:0]  a_i, b_i;
    logic        start;
    logic [15:0] result, sum_in_a, sum_in_b, sum_out;
    logic        busy;

    logic [15:0] chk_a, chk_b, chk_sum;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] last_exp = 16'h0000;
    logic        prev_busy = 1'b0;
    int          bcnt = 0;

    mul_8x8 #(.WIDTH(8)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .a_i      (a_i),
        .b_i      (b_i),
        .start    (start),
        .result   (result),
        .busy     (busy),
        .sum_in_a (sum_in_a),
        .sum_in_b (sum_in_b),
        .sum_out  (sum_out)
    );

    sum_16 u_add (
        .a      (sum_in_a),
        .b      (sum_in_b),
        .result (sum_out)
    );

    sum_16 u_add_chk (
        .a      (chk_a),
        .b      (chk_b),
        .result (chk_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: result must hold during RUN, and each busy fall
    // retires one expected product after exactly eight busy cycles.
    always @(negedge clk) begin
        if (!rst) begin
            prev_busy = 1'b0;
            bcnt      = 0;
            last_exp  = 16'h0000;
        end else begin
            if (busy) begin
                bcnt++;
                check("hold", int'(result), int'(last_exp));
            end else if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("result", int'(result), int'(e));
                    check("latency", bcnt, 8);
                    last_exp = e;
                end
                bcnt = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("timeout_idle", 0, 1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
        @(negedge clk);
        a_i   = a;
        b_i   = b;
        start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", int'(busy), 1);
        wait_idle();
    endtask

    initial begin
        rst   = 1'b0;
        a_i   = '0;
        b_i   = '0;
        start = 1'b0;
        chk_a = '0;
        chk_b = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_result", int'(result), 0);
        check("rst_sum_a", int'(sum_in_a), 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_sum_b", int'(sum_in_b), 0);

        run_op(8'd3, 8'd2, 16'd6);
        run_op(8'd5, 8'd5, 16'd25);
        run_op(8'd4, 8'd3, 16'd12);
        run_op(8'd255, 8'd255, 16'hFE01);
        run_op(8'd255, 8'd0, 16'd0);

        // start pulsed mid-operation with new operands must be ignored
        @(negedge clk);
        a_i = 8'd7; b_i = 8'd9; start = 1'b1;
        exp_q.push_back(16'd63);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a_i = 8'd1; b_i = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        run_op(8'd1, 8'd1, 16'd1);

        // start held high: back-to-back operations
        @(negedge clk);
        a_i = 8'd2; b_i = 8'd3; start = 1'b1;
        exp_q.push_back(16'd6);
        exp_q.push_back(16'd6);
        wait_idle();
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (busy) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("restart_held", int'(seen), 1);
        end
        start = 1'b0;
        wait_idle();

        // reset during RUN aborts with no partial product
        @(negedge clk);
        a_i = 8'd200; b_i = 8'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_result", int'(result), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle", int'(busy), 0);
        run_op(8'd12, 8'd12, 16'd144);

        chk_a = 16'hFFFF; chk_b = 16'h0001;
        #1 check("sum_wrap", int'(chk_sum), 32'h0000);
        chk_a = 16'h1234; chk_b = 16'h0101;
        #1 check("sum_plain", int'(chk_sum), 32'h1335);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mul_8x8

`default_nettype wire
